// File: rtl/display_mux.sv
// display_mux: time-multiplexes a mod-12 / mod-10 counter pair onto three
// seven-segment digits. Inputs are snapshotted once per frame so that a
// frame never mixes two different counter states.
module display_mux #(
  parameter int unsigned SCAN_DIV       = 1000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] cont_12_in,
  input  logic [3:0] cont_10_in,
  input  logic       blank,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       err
);

  localparam logic [15:0] LP_LAST    = 16'(SCAN_DIV - 1);
  localparam logic [6:0]  LP_SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [3:0]  LP_CODE_E  = 4'hE;

  logic [15:0] r_presc;
  logic [1:0]  r_digit;
  logic [3:0]  r_sh12;
  logic [3:0]  r_sh10;

  logic        w_tick;
  logic        w_capture;
  logic        w_bad12;
  logic        w_bad10;
  logic        w_tens;
  logic [3:0]  w_ones;
  logic [3:0]  w_code;
  logic [2:0]  w_an_nxt;
  logic [6:0]  w_seg_nxt;

  // Active-high gfedcba pattern for a digit code; E is the error glyph.
  function automatic logic [6:0] seg_hi(input logic [3:0] code);
    logic [6:0] pat;
    case (code)
      4'd0:      pat = 7'h3F;
      4'd1:      pat = 7'h06;
      4'd2:      pat = 7'h5B;
      4'd3:      pat = 7'h4F;
      4'd4:      pat = 7'h66;
      4'd5:      pat = 7'h6D;
      4'd6:      pat = 7'h7D;
      4'd7:      pat = 7'h07;
      4'd8:      pat = 7'h7F;
      4'd9:      pat = 7'h6F;
      LP_CODE_E: pat = 7'h79;
      default:   pat = 7'h00;
    endcase
    return pat;
  endfunction

  // Apply the board's segment polarity.
  function automatic logic [6:0] seg_pol(input logic [6:0] pat);
    return SEG_ACTIVE_LOW ? ~pat : pat;
  endfunction

  assign w_tick    = (r_presc == LP_LAST);
  assign w_capture = w_tick && (r_digit == 2'd2);
  assign w_bad12   = (r_sh12 > 4'd11);
  assign w_bad10   = (r_sh10 > 4'd9);
  assign w_tens    = (r_sh12 >= 4'd10);
  assign w_ones    = w_tens ? (r_sh12 - 4'd10) : r_sh12;

  // Prescaler: counts 0..SCAN_DIV-1 and wraps; tick on the last count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        r_presc <= '0;
    else if (w_tick) r_presc <= '0;
    else             r_presc <= r_presc + 16'd1;
  end

  // Digit slot index: 0 -> 1 -> 2 -> 0, advancing only on tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    r_digit <= '0;
    else if (w_tick) r_digit <= (r_digit == 2'd2) ? 2'd0 : r_digit + 2'd1;
  end

  // Frame snapshot: load both counts at the end of the digit2 slot only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sh12 <= '0;
      r_sh10 <= '0;
    end else if (w_capture) begin
      r_sh12 <= cont_12_in;
      r_sh10 <= cont_10_in;
    end
  end

  // Select the active digit, its glyph, leading-zero and global blanking.
  always_comb begin
    w_an_nxt  = 3'b111;
    w_code    = 4'd0;
    w_seg_nxt = LP_SEG_OFF;
    case (r_digit)
      2'd0: begin
        w_an_nxt = 3'b110;
        w_code   = w_bad10 ? LP_CODE_E : r_sh10;
      end
      2'd1: begin
        w_an_nxt = 3'b101;
        w_code   = w_bad12 ? LP_CODE_E : w_ones;
      end
      2'd2: begin
        if (w_bad12) begin
          w_an_nxt = 3'b011;
          w_code   = LP_CODE_E;
        end else if (w_tens) begin
          w_an_nxt = 3'b011;
          w_code   = 4'd1;
        end
      end
      default: ;
    endcase
    if (blank) w_an_nxt = 3'b111;
    if (w_an_nxt != 3'b111) w_seg_nxt = seg_pol(seg_hi(w_code));
  end

  // Output registers: one cycle behind the slot index and snapshot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an  <= 3'b111;
      seg <= LP_SEG_OFF;
      err <= 1'b0;
    end else begin
      an  <= w_an_nxt;
      seg <= w_seg_nxt;
      err <= w_bad12 || w_bad10;
    end
  end

endmodule
